// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter and receiver. Rev 1.0
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with wrap-bit pointers, push/pop/full/empty/level. Rev 1.0
`default_nettype none

module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // The extra MSB on each pointer separates full (MSBs differ) from empty.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter with FIFO front end and programmable bit period. Rev 1.0
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int    DIV_WIDTH  = 16,
    parameter int    FIFO_DEPTH = 4,
    parameter string PARITY     = "NONE",
    parameter int    STOP_BITS  = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DIV_WIDTH-1:0]          div_i,
    input  logic                          req_i,
    input  logic [UART_DATA_BITS-1:0]     data_i,
    output logic                          ack_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam logic [1:0] PAR_MODE  = (PARITY == "EVEN") ? PAR_EVEN :
                                       (PARITY == "ODD")  ? PAR_ODD  : PAR_NONE;
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);

    uart_tx_state_e              state;
    logic [DIV_WIDTH-1:0]        cnt;
    logic [DIV_WIDTH-1:0]        div_q;
    logic [DIV_WIDTH-1:0]        div_eff;
    logic [2:0]                  bit_idx;
    logic [UART_DATA_BITS-1:0]   shift;
    logic                        par;
    logic                        bit_end;
    logic                        pop;
    logic                        line;
    logic                        full;
    logic                        empty;
    logic [UART_DATA_BITS-1:0]   fifo_data;

    uart_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (req_i),
        .wdata (data_i),
        .pop   (pop),
        .rdata (fifo_data),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    assign ack_o   = ~full;
    assign div_eff = (div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_i;
    assign bit_end = (cnt == '0);

    // Pop from IDLE, or on the final cycle of the last stop bit so frames abut.
    assign pop = ~empty && ((state == S_IDLE) ||
                            (state == S_STOP && bit_end && bit_idx == LAST_STOP));

    always_comb begin
        line = 1'b1;
        case (state)
            S_START:  line = 1'b0;
            S_DATA:   line = shift[0];
            S_PARITY: line = par;
            default:  line = 1'b1;
        endcase
    end

    // The line register trails the state by one cycle, so every bit keeps its full width.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            div_q   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
        end else begin
            tx_o   <= line;
            busy_o <= (state != S_IDLE) || ~empty;
            if (pop) begin
                state   <= S_START;
                shift   <= fifo_data;
                par     <= (^fifo_data) ^ (PAR_MODE == PAR_ODD);
                div_q   <= div_eff;
                cnt     <= div_eff - DIV_WIDTH'(1);
                bit_idx <= '0;
            end else if (state != S_IDLE) begin
                if (!bit_end) begin
                    cnt <= cnt - DIV_WIDTH'(1);
                end else begin
                    cnt <= div_q - DIV_WIDTH'(1);
                    case (state)
                        S_START: begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                        S_DATA: begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == LAST_DATA) begin
                                bit_idx <= '0;
                                state   <= (PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
                            end
                        end
                        S_PARITY: begin
                            state   <= S_STOP;
                            bit_idx <= '0;
                        end
                        S_STOP: begin
                            if (bit_idx == LAST_STOP) state <= S_IDLE;
                            else                      bit_idx <= bit_idx + 3'd1;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx against a frame-level line model. Rev 1.0
`default_nettype none

module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] div = 16'd4;
    logic [7:0]  data = 8'h00;
    logic [2:0]  req = 3'b000;
    logic [2:0]  ack;
    logic [2:0]  tx;
    logic [2:0]  busy;
    logic [2:0]  level [3];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q [$];
    logic        saw_full = 1'b0;

    always #5 clk = ~clk;

    // dut0: no parity, 1 stop; dut1: even parity, 2 stops; dut2: odd parity, 1 stop
    uart_tx #(.DIV_WIDTH(16), .FIFO_DEPTH(4), .PARITY("NONE"), .STOP_BITS(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .div_i(div), .req_i(req[0]), .data_i(data),
        .ack_o(ack[0]), .tx_o(tx[0]), .busy_o(busy[0]), .level_o(level[0]));
    uart_tx #(.DIV_WIDTH(16), .FIFO_DEPTH(4), .PARITY("EVEN"), .STOP_BITS(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .div_i(div), .req_i(req[1]), .data_i(data),
        .ack_o(ack[1]), .tx_o(tx[1]), .busy_o(busy[1]), .level_o(level[1]));
    uart_tx #(.DIV_WIDTH(16), .FIFO_DEPTH(4), .PARITY("ODD"), .STOP_BITS(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .div_i(div), .req_i(req[2]), .data_i(data),
        .ack_o(ack[2]), .tx_o(tx[2]), .busy_o(busy[2]), .level_o(level[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_bits(input int sel);
        return 1 + 8 + ((sel != 0) ? 1 : 0) + ((sel == 1) ? 2 : 1);
    endfunction

    // Line level for each bit slot of a frame: start, data LSB first, parity, stops.
    function automatic logic [11:0] frame_vec(input int sel, input logic [7:0] b);
        logic [11:0] v;
        int ones;
        v    = '1;
        ones = 0;
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v[1 + i] = b[i];
            ones += int'(b[i]);
        end
        if (sel == 1)      v[9] = (ones % 2 == 1);
        else if (sel == 2) v[9] = (ones % 2 == 0);
        return v;
    endfunction

    task automatic push(input int sel, input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        data     = b;
        req[sel] = 1'b1;
        while (ack[sel] !== 1'b1 && t < 400) begin
            if (level[sel] == 3'd4) begin
                saw_full = 1'b1;
                chk("ack_when_full", 32'(ack[sel]), 32'd0);
            end
            @(negedge clk);
            t++;
        end
        n_cmp++;
        assert (t < 400) else begin
            n_bad++;
            $error("FAIL push_timeout: waited %0d cycles, expected < 400", t);
        end
        @(posedge clk);
        exp_q.push_back(b);
    endtask

    task automatic idle_req();
        @(negedge clk);
        req = 3'b000;
    endtask

    task automatic expect_frames(input int sel, input int n, input int dv, input bit b2b,
                                 input string tag, output int waited);
        int len;
        int t;
        logic [7:0]  b;
        logic [11:0] v;
        len    = frame_bits(sel) * dv;
        waited = 0;
        for (int k = 0; k < n; k++) begin
            if (k == 0 || !b2b) begin
                @(negedge clk);
                t = 0;
                while (tx[sel] !== 1'b0 && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                n_cmp++;
                assert (t < 500) else begin
                    n_bad++;
                    $error("FAIL %s_start: no start bit after %0d cycles, expected < 500", tag, t);
                end
                if (t >= 500) return;
                if (k == 0) waited = t;
            end else begin
                @(negedge clk);
            end
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_bad++;
                $error("FAIL %s_extra: frame seen with %0d queued bytes, expected > 0", tag, exp_q.size());
            end
            if (exp_q.size() == 0) return;
            b = exp_q.pop_front();
            v = frame_vec(sel, b);
            for (int c = 0; c < len; c++) begin
                if (c > 0) @(negedge clk);
                chk(tag, 32'(tx[sel]), 32'(v[c / dv]));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int dv;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("rst_tx",    32'(tx[s]),    32'd1);
            chk("rst_ack",   32'(ack[s]),   32'd1);
            chk("rst_busy",  32'(busy[s]),  32'd0);
            chk("rst_level", 32'(level[s]), 32'd0);
        end

        // First frame: 0x55 at div 4, latency and busy timing
        div = 16'd4;
        push(0, 8'h55);
        @(negedge clk);
        req = 3'b000;
        chk("lat_lvl1",  32'(level[0]), 32'd1);
        chk("lat_busy0", 32'(busy[0]),  32'd0);
        chk("lat_tx1",   32'(tx[0]),    32'd1);
        @(negedge clk);
        chk("lat_busy1", 32'(busy[0]),  32'd1);
        chk("lat_lvl0",  32'(level[0]), 32'd0);
        chk("lat_tx1b",  32'(tx[0]),    32'd1);
        expect_frames(0, 1, 4, 1'b0, "frame55", w);
        chk("start_latency", 32'(w), 32'd0);
        chk("busy_last_stop", 32'(busy[0]), 32'd1);
        @(negedge clk);
        chk("busy_fall", 32'(busy[0]), 32'd0);
        chk("tx_idle",   32'(tx[0]),   32'd1);

        // Random single frames on every parity flavour, plus fixed 0x07 parity cases
        for (int s = 0; s < 3; s++) begin
            for (int r = 0; r < 3; r++) begin
                dv  = int'($urandom_range(2, 7));
                div = 16'(dv);
                d   = (r == 0) ? 8'h07 : 8'($urandom);
                if (r == 0) begin
                    dv  = 2;
                    div = 16'd2;
                end
                push(s, d);
                idle_req();
                expect_frames(s, 1, dv, 1'b0, "rand_frame", w);
            end
        end

        // Six bytes with req held: FIFO fills, frames abut
        div = 16'd3;
        saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) push(0, 8'($urandom));
                idle_req();
            end
            expect_frames(0, 6, 3, 1'b1, "burst", w);
        join
        chk("saw_full", 32'(saw_full), 32'd1);

        // Push coinciding with a pop at level 2
        div = 16'd2;
        fork
            begin
                push(0, 8'hA1);
                push(0, 8'hB2);
                push(0, 8'hC3);
                @(negedge clk);
                req = 3'b000;
                repeat (18) @(posedge clk);
                @(negedge clk);
                chk("lvl_pre_sim", 32'(level[0]), 32'd2);
                data   = 8'hD4;
                req[0] = 1'b1;
                @(posedge clk);
                exp_q.push_back(8'hD4);
                @(negedge clk);
                req = 3'b000;
                chk("lvl_post_sim", 32'(level[0]), 32'd2);
            end
            expect_frames(0, 4, 2, 1'b1, "simul", w);
        join

        // div 0 and 1 act as 2
        div = 16'd0;
        push(0, 8'($urandom));
        idle_req();
        expect_frames(0, 1, 2, 1'b0, "div0", w);
        div = 16'd1;
        push(0, 8'($urandom));
        idle_req();
        expect_frames(0, 1, 2, 1'b0, "div1", w);

        // div change mid-frame only affects the next frame
        div = 16'd4;
        fork
            begin
                push(0, 8'h3C);
                idle_req();
                repeat (10) @(negedge clk);
                div = 16'd8;
            end
            expect_frames(0, 1, 4, 1'b0, "div_keep", w);
        join
        push(0, 8'hC5);
        idle_req();
        expect_frames(0, 1, 8, 1'b0, "div_next", w);

        // Reset during DATA bit 3 with a second byte queued
        div = 16'd4;
        push(0, 8'hE7);
        push(0, 8'h18);
        idle_req();
        repeat (17) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tx",    32'(tx[0]),    32'd1);
        chk("midrst_level", 32'(level[0]), 32'd0);
        chk("midrst_busy",  32'(busy[0]),  32'd0);
        rst = 1'b0;
        exp_q.delete();
        push(0, 8'h9B);
        idle_req();
        expect_frames(0, 1, 4, 1'b0, "after_rst", w);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
